mod_source_ctrl: RTL and testbench
==================================

Name: mod_source_ctrl

Overview:
Timing and modulation-source stage directly upstream of the DDS waveform/modulation selector. It generates the DDS sample-enable strobe and a slow symbol tick. It steps a 5-bit maximal-length LFSR once per symbol and supplies the serial data bit for ASK/BPSK/LFSR modulation. It also drives the DDS phase increment, switching between two frequencies per symbol when FSK is selected.

Parameters:
SAMPLE_DIV, 5000, clk cycles per sample_en pulse (10 kHz at 50 MHz); legal range >= 1
SYMBOL_DIV, 10000, sample_en pulses per symbol tick (1 Hz default); legal range >= 1
PHASE_W, 32, phase increment width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  1 = free-running; 0 = freeze counters and LFSR
mod_sel  input  4  modulation select (ASK=0, FSK=1, BPSK=2, LFSR=3)
phase_inc_base  input  PHASE_W  nominal/FSK "0" phase increment
phase_inc_alt  input  PHASE_W  FSK "1" phase increment
sample_en  output  1  one-cycle DDS sample strobe
symbol_tick  output  1  one-cycle pulse at each LFSR step
lfsr_bit  output  1  current data bit (lfsr_state[0])
lfsr_state  output  5  full LFSR register
frame_start  output  1  one-cycle pulse when LFSR returns to seed
phase_inc_out  output  PHASE_W  phase increment to DDS

Behaviour:
- Async reset (any time, including mid-symbol): sample counter=0, symbol counter=0, sample_en=0, symbol_tick=0, frame_start=0, lfsr_state=5'b00001, lfsr_bit=1, shadow base/alt=0, phase_inc_out=0.
- Sample counter: counts 0..SAMPLE_DIV-1 only while run=1. sample_en is registered and high for the single cycle after the counter is at SAMPLE_DIV-1, then the counter wraps to 0. First pulse comes SAMPLE_DIV cycles after reset release with run=1. SAMPLE_DIV=1 gives sample_en continuously high.
- Symbol counter: increments only on cycles where the sample counter wraps, counting 0..SYMBOL_DIV-1. symbol_tick asserts in the same cycle as the sample_en of the wrapping sample, so every symbol_tick coincides with a sample_en.
- LFSR: Fibonacci, right shift. Next state = {s0^s2, s4:s1}. Period 31. It advances on the same edge that raises symbol_tick, so lfsr_bit changes with symbol_tick high. From seed 00001 the sequence is 10000, 01000, 00100, 10010, 01001, and so on.
- Lock-up guard: if the next state would be 00000, load 00001 instead. This state is unreachable in normal operation.
- frame_start: high in the cycle where lfsr_state becomes 00001 through a step. It is not asserted by reset.
- Shadow registers: shadow_base and shadow_alt load phase_inc_base and phase_inc_alt on the symbol_tick edge, or on every cycle while run=0. Input changes mid-symbol therefore take effect only at the next symbol boundary.
- phase_inc_out: registered every cycle.
  - If mod_sel==FSK and lfsr_bit==1: shadow_alt.
  - Otherwise: shadow_base.
  - Latency is 1 cycle after an lfsr_bit change or a mod_sel change. mod_sel is not shadowed.
- run=0: counters and LFSR hold their values. sample_en, symbol_tick and frame_start are forced low on the next edge. phase_inc_out keeps tracking the shadows, which are loading each cycle.
- run 0->1: counting resumes from the held values with no extra pulse.
- Unknown mod_sel values behave like non-FSK (phase_inc_out = shadow_base).

Decomposition:
- Package mod_pkg:
  - mod_sel encodings MOD_ASK=4'd0, MOD_FSK=4'd1, MOD_BPSK=4'd2, MOD_LFSR=4'd3
  - LFSR_W=5, LFSR_SEED=5'b00001
- Sub-module lfsr5: ports clk, reset, step, state[4:0]. It holds the feedback and lock-up guard, and is reused by any later noise source.
- Counter widths come from $clog2 of SAMPLE_DIV and SYMBOL_DIV.

Test Plan:
1. SAMPLE_DIV=4, SYMBOL_DIV=3, run=1 after reset: sample_en high on cycles 4, 8, 12, ...; symbol_tick on cycles 12 and 24. lfsr_state after ticks: 10000, 01000, 00100, 10010, 01001.
2. Run 31 symbol ticks: frame_start pulses exactly once, on tick 31, with lfsr_state=00001. The 31 states visited are all distinct and none is 00000.
3. mod_sel=FSK, base=32'h100, alt=32'h200: phase_inc_out=32'h100 while lfsr_bit=0. It becomes 32'h200 one cycle after a tick that sets lfsr_bit=1. With mod_sel=ASK it stays 32'h100 throughout.
4. Change phase_inc_base from 32'h100 to 32'h300 mid-symbol: phase_inc_out stays 32'h100 until the next symbol_tick, then becomes 32'h300 one cycle later.
5. Drop run for 10 cycles mid-count: sample_en and symbol_tick stay low, and lfsr_state and counters hold. After run returns, the next sample_en arrives after the remaining count, not a full SAMPLE_DIV.
6. Assert reset asynchronously between clock edges mid-symbol: all outputs go to their reset values immediately (lfsr_state=00001, phase_inc_out=0). After release the first sample_en comes SAMPLE_DIV cycles later.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared modulation-source definitions: mod_sel encodings and the 5-bit LFSR
// step rule used by every LFSR-based source.
package mod_pkg;

   typedef enum logic [3:0] {
      MOD_ASK  = 4'd0,
      MOD_FSK  = 4'd1,
      MOD_BPSK = 4'd2,
      MOD_LFSR = 4'd3
   } mod_sel_e;

   localparam int             LFSR_W    = 5;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

   // Fibonacci right shift with feedback s0^s2; an all-zero result reloads the seed
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] n;
      n = {s[0] ^ s[2], s[4:1]};
      if (n == '0) begin
         n = LFSR_SEED;
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr5.sv
// 5-bit maximal-length LFSR (period 31) that advances one position per step
// pulse and holds otherwise.
module lfsr5
   import mod_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   output logic [4:0] state
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (step) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LFSR_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/mod_source_ctrl.sv
// Sample/symbol timebase, LFSR data source and symbol-aligned phase increment
// selection feeding the DDS modulation selector.
module mod_source_ctrl
   import mod_pkg::*;
#(
   parameter int SAMPLE_DIV = 5000,
   parameter int SYMBOL_DIV = 10000,
   parameter int PHASE_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [3:0]         mod_sel,
   input  logic [PHASE_W-1:0] phase_inc_base,
   input  logic [PHASE_W-1:0] phase_inc_alt,
   output logic               sample_en,
   output logic               symbol_tick,
   output logic               lfsr_bit,
   output logic [4:0]         lfsr_state,
   output logic               frame_start,
   output logic [PHASE_W-1:0] phase_inc_out
);

   localparam int SAMPLE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int SYMBOL_W = (SYMBOL_DIV > 1) ? $clog2(SYMBOL_DIV) : 1;

   logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [SYMBOL_W-1:0] symbol_cnt_q, symbol_cnt_d;
   logic                sample_en_q, sample_en_d;
   logic                symbol_tick_q, symbol_tick_d;
   logic                frame_start_q, frame_start_d;
   logic [PHASE_W-1:0]  shadow_base_q, shadow_base_d;
   logic [PHASE_W-1:0]  shadow_alt_q, shadow_alt_d;
   logic [PHASE_W-1:0]  phase_inc_q, phase_inc_d;
   logic                sample_wrap;
   logic                symbol_wrap;

   assign sample_wrap = run && (sample_cnt_q == SAMPLE_W'(SAMPLE_DIV - 1));
   assign symbol_wrap = sample_wrap && (symbol_cnt_q == SYMBOL_W'(SYMBOL_DIV - 1));

   lfsr5 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .step  (symbol_wrap),
      .state (lfsr_state)
   );

   // Strobes are registered from the wrap conditions, so they line up with the
   // LFSR step and shadow load that happen on the same edge.
   always_comb begin
      sample_cnt_d  = sample_cnt_q;
      symbol_cnt_d  = symbol_cnt_q;
      sample_en_d   = sample_wrap;
      symbol_tick_d = symbol_wrap;
      frame_start_d = symbol_wrap && (lfsr_next(lfsr_state) == LFSR_SEED);
      if (run) begin
         sample_cnt_d = sample_wrap ? '0 : sample_cnt_q + SAMPLE_W'(1);
         if (sample_wrap) begin
            symbol_cnt_d = symbol_wrap ? '0 : symbol_cnt_q + SYMBOL_W'(1);
         end
      end
   end

   // Shadows track the inputs while stopped so a restart begins with fresh values
   always_comb begin
      shadow_base_d = shadow_base_q;
      shadow_alt_d  = shadow_alt_q;
      if (symbol_wrap || !run) begin
         shadow_base_d = phase_inc_base;
         shadow_alt_d  = phase_inc_alt;
      end
      phase_inc_d = ((mod_sel == MOD_FSK) && lfsr_state[0]) ? shadow_alt_q : shadow_base_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_cnt_q  <= '0;
         symbol_cnt_q  <= '0;
         sample_en_q   <= 1'b0;
         symbol_tick_q <= 1'b0;
         frame_start_q <= 1'b0;
         shadow_base_q <= '0;
         shadow_alt_q  <= '0;
         phase_inc_q   <= '0;
      end else begin
         sample_cnt_q  <= sample_cnt_d;
         symbol_cnt_q  <= symbol_cnt_d;
         sample_en_q   <= sample_en_d;
         symbol_tick_q <= symbol_tick_d;
         frame_start_q <= frame_start_d;
         shadow_base_q <= shadow_base_d;
         shadow_alt_q  <= shadow_alt_d;
         phase_inc_q   <= phase_inc_d;
      end
   end

   assign sample_en     = sample_en_q;
   assign symbol_tick   = symbol_tick_q;
   assign frame_start   = frame_start_q;
   assign lfsr_bit      = lfsr_state[0];
   assign phase_inc_out = phase_inc_q;

endmodule

// File: tb/tb_mod_source_ctrl.sv
// Randomized bench for mod_source_ctrl, compared every cycle against a
// behavioural model built from running-cycle counts and a tabulated LFSR sequence.
module tb_mod_source_ctrl;

   localparam int SD = 4;
   localparam int YD = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic [3:0]  modSel;
   logic [31:0] incBase;
   logic [31:0] incAlt;
   logic        sampleEn;
   logic        symbolTick;
   logic        lfsrBit;
   logic [4:0]  lfsrState;
   logic        frameStart;
   logic [31:0] phaseOut;

   int errors = 0;
   int checks = 0;

   // Model state: everything derives from counts of running edges and of ticks
   logic [4:0]  seq [31];
   int          runCount;
   int          tickCount;
   logic [31:0] shBase, shAlt;
   logic        expSample, expTick, expFrame;
   logic [31:0] expPhase;
   logic [4:0]  tickStates [31];
   int          framesSeen;

   mod_source_ctrl #(.SAMPLE_DIV(SD), .SYMBOL_DIV(YD), .PHASE_W(32)) dut (
      .clk            (clock),
      .reset          (reset),
      .run            (run),
      .mod_sel        (modSel),
      .phase_inc_base (incBase),
      .phase_inc_alt  (incAlt),
      .sample_en      (sampleEn),
      .symbol_tick    (symbolTick),
      .lfsr_bit       (lfsrBit),
      .lfsr_state     (lfsrState),
      .frame_start    (frameStart),
      .phase_inc_out  (phaseOut)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      runCount  = 0;
      tickCount = 0;
      shBase    = '0;
      shAlt     = '0;
      expSample = 1'b0;
      expTick   = 1'b0;
      expFrame  = 1'b0;
      expPhase  = '0;
   endtask

   task automatic checkAll();
      checkOutput("sample_en",   {31'd0, sampleEn},   {31'd0, expSample});
      checkOutput("symbol_tick", {31'd0, symbolTick}, {31'd0, expTick});
      checkOutput("frame_start", {31'd0, frameStart}, {31'd0, expFrame});
      checkOutput("lfsr_state",  {27'd0, lfsrState},  {27'd0, seq[tickCount % 31]});
      checkOutput("lfsr_bit",    {31'd0, lfsrBit},    {31'd0, seq[tickCount % 31][0]});
      checkOutput("phase_inc",   phaseOut,            expPhase);
   endtask

   // One clock edge: model advances from pre-edge inputs, outputs sampled #1 after
   task automatic applyStimulus();
      logic preBit;
      logic preRun;
      preBit = seq[tickCount % 31][0];
      preRun = run;
      @(posedge clock);
      expPhase = ((modSel == 4'd1) && preBit) ? shAlt : shBase;
      expSample = 1'b0;
      expTick   = 1'b0;
      expFrame  = 1'b0;
      if (preRun) begin
         runCount++;
         expSample = (runCount % SD) == 0;
         expTick   = (runCount % (SD * YD)) == 0;
         if (expTick) begin
            tickCount++;
            expFrame = (tickCount % 31) == 0;
         end
      end
      if (!preRun || expTick) begin
         shBase = incBase;
         shAlt  = incAlt;
      end
      #1;
      checkAll();
      if (expTick && tickCount <= 31) begin
         tickStates[tickCount - 1] = lfsrState;
         if (frameStart) framesSeen++;
      end
   endtask

   task automatic randomInputs();
      if ($urandom_range(15) == 0) run = ~run;
      else if (!run && $urandom_range(3) == 0) run = 1'b1;
      if ($urandom_range(31) == 0) modSel = 4'($urandom_range(5));
      if ($urandom_range(9) == 0) incBase = $urandom;
      if ($urandom_range(9) == 0) incAlt = $urandom;
   endtask

   initial begin
      int distinct;
      logic [4:0] s;
      seq[0] = 5'b00001;
      for (int i = 1; i < 31; i++) begin
         s = seq[i-1];
         seq[i] = {s[0] ^ s[2], s[4], s[3], s[2], s[1]};
         if (seq[i] == 5'b00000) seq[i] = 5'b00001;
      end
      framesSeen = 0;

      reset   = 1'b1;
      run     = 1'b0;
      modSel  = 4'd1;
      incBase = 32'h100;
      incAlt  = 32'h200;
      modelReset();
      repeat (2) @(posedge clock);
      #1;
      checkAll();
      @(negedge clock);
      reset = 1'b0;
      run   = 1'b1;

      // Directed start: fixed FSK increments, then the mid-symbol base change
      for (int c = 1; c <= 30; c++) begin
         if (c == 18) incBase = 32'h300;
         applyStimulus();
         if (c == 4)  checkOutput("first_sample", {31'd0, sampleEn}, 32'd1);
         if (c == 12) checkOutput("first_tick_state", {27'd0, lfsrState}, 32'h10);
         if (c == 13) checkOutput("fsk_base_lfsr0", phaseOut, 32'h100);
         if (c == 25) checkOutput("base_after_tick", phaseOut, 32'h300);
      end

      // Freeze for 10 cycles mid-count
      run = 1'b0;
      for (int c = 0; c < 10; c++) applyStimulus();
      run = 1'b1;

      for (int c = 0; c < 800; c++) begin
         randomInputs();
         applyStimulus();
      end

      distinct = 0;
      for (int i = 0; i < 31; i++) begin
         int dup;
         dup = 0;
         for (int j = 0; j < i; j++) if (tickStates[j] == tickStates[i]) dup = 1;
         if (dup == 0 && tickStates[i] != 5'b00000) distinct++;
      end
      checkOutput("distinct_states", distinct, 32'd31);
      checkOutput("frames_in_period", framesSeen, 32'd1);
      checkOutput("tick31_state", {27'd0, tickStates[30]}, 32'h01);

      // Asynchronous reset between edges, mid-symbol
      run = 1'b1;
      for (int c = 0; c < 17; c++) applyStimulus();
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkAll();
      checkOutput("async_phase", phaseOut, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         applyStimulus();
         if (c == SD) checkOutput("post_reset_sample", {31'd0, sampleEn}, 32'd1);
      end
      for (int c = 0; c < 200; c++) begin
         randomInputs();
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
